// File: rtl/local_sp_stream_reader.sv
// ---------------------------------------------------------------------------
// local_sp_stream_reader
//   Read-side initiator for a single-port local scratchpad memory. A start
//   command latches a base address and a word count. The block then issues
//   that many sequential reads, wrapping modulo AddressRange. Each returned
//   word is captured after ReadLatency cycles into a small output FIFO, and
//   the FIFO drives a valid/ready stream. Reads are issued only while
//   (inflight + fifo_count) < FifoDepth. Every issued read therefore has a
//   guaranteed FIFO slot, and backpressure never loses data.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               command pulse, honoured only in IDLE
//   base_addr, count    command arguments, latched on start
//   busy, done          command status (done is a one-cycle pulse)
//   mem_address0/ce0/we0/d0, mem_q0
//                       memory port (write side tied off)
//   m_tdata/m_tvalid/m_tready/m_tlast
//                       output stream; m_tlast marks the final word
// ---------------------------------------------------------------------------
module local_sp_stream_reader #(
   parameter int DataWidth    = 256,
   parameter int AddressWidth = 11,
   parameter int AddressRange = 2048,
   parameter int ReadLatency  = 2,
   parameter int FifoDepth    = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [AddressWidth-1:0] base_addr,
   input  logic [AddressWidth:0]   count,
   output logic                    busy,
   output logic                    done,
   output logic [AddressWidth-1:0] mem_address0,
   output logic                    mem_ce0,
   output logic                    mem_we0,
   output logic [DataWidth-1:0]    mem_d0,
   input  logic [DataWidth-1:0]    mem_q0,
   output logic [DataWidth-1:0]    m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast
);

   localparam int CntW = $clog2(FifoDepth + 1);
   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

   localparam logic [AddressWidth-1:0] AddrZero = {AddressWidth{1'b0}};
   localparam logic [AddressWidth-1:0] AddrOne  = AddressWidth'(1);
   localparam logic [AddressWidth-1:0] AddrLast = AddressWidth'(AddressRange - 1);
   localparam logic [AddressWidth:0]   RemZero  = {(AddressWidth+1){1'b0}};
   localparam logic [AddressWidth:0]   RemOne   = (AddressWidth+1)'(1);
   localparam logic [CntW-1:0]         CntZero  = {CntW{1'b0}};
   localparam logic [CntW-1:0]         CntOne   = CntW'(1);
   localparam logic [CntW:0]           CreditMax = (CntW+1)'(FifoDepth);
   localparam logic [PtrW-1:0]         PtrZero  = {PtrW{1'b0}};
   localparam logic [PtrW-1:0]         PtrOne   = PtrW'(1);
   localparam logic [PtrW-1:0]         PtrLast  = PtrW'(FifoDepth - 1);
   localparam logic [DataWidth-1:0]    DataZero = {DataWidth{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [AddressWidth-1:0] addr, addr_nxt;
   logic [AddressWidth:0]   remaining, remaining_nxt;
   logic [CntW-1:0]         inflight, inflight_nxt;
   logic [CntW-1:0]         fifo_count, fifo_count_nxt;
   logic [CntW:0]           credit_nxt;
   logic [ReadLatency-1:0]  pipe_vld, pipe_vld_nxt;
   logic [ReadLatency-1:0]  pipe_last, pipe_last_nxt;
   logic [DataWidth-1:0]    fifo_data [FifoDepth];
   logic [FifoDepth-1:0]    fifo_last;
   logic [PtrW-1:0]         wr_ptr, rd_ptr;
   logic                    issue, ret, ret_last, push, pop, ce0_nxt;

   // Next sequential address, wrapping at the top of the memory.
   function automatic logic [AddressWidth-1:0] next_addr(input logic [AddressWidth-1:0] a);
      if (a == AddrLast) begin
         return AddrZero;
      end else begin
         return a + AddrOne;
      end
   endfunction

   // Next FIFO pointer, wrapping at the last entry.
   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      if (p == PtrLast) begin
         return PtrZero;
      end else begin
         return p + PtrOne;
      end
   endfunction

   // mem_ce0 is the registered issue decision for the current cycle.
   assign issue    = mem_ce0;
   assign ret      = pipe_vld[ReadLatency-1];
   assign ret_last = pipe_last[ReadLatency-1];
   assign push     = ret;
   assign pop      = m_tvalid & m_tready;

   assign mem_we0  = 1'b0;
   assign mem_d0   = DataZero;
   // Gate the head so an empty FIFO presents all-zero outputs.
   assign m_tdata  = m_tvalid ? fifo_data[rd_ptr] : DataZero;
   assign m_tlast  = m_tvalid & fifo_last[rd_ptr];

   // Command FSM and address/remaining bookkeeping.
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      remaining_nxt = remaining;
      case (state)
         IDLE: begin
            if (start) begin
               addr_nxt      = base_addr;
               remaining_nxt = count;
               if (count != RemZero) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt = DONE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (issue) begin
               addr_nxt      = next_addr(addr);
               remaining_nxt = remaining - RemOne;
               if (remaining == RemOne) begin
                  state_nxt = DRAIN;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               state_nxt = RUN;
            end
         end
         DRAIN: begin
            if (pop && m_tlast) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DRAIN;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Credit counters, return-tag pipe and the next-cycle issue decision.
   always_comb begin
      case ({issue, ret})
         2'b10:   inflight_nxt = inflight + CntOne;
         2'b01:   inflight_nxt = inflight - CntOne;
         default: inflight_nxt = inflight;
      endcase
      case ({push, pop})
         2'b10:   fifo_count_nxt = fifo_count + CntOne;
         2'b01:   fifo_count_nxt = fifo_count - CntOne;
         default: fifo_count_nxt = fifo_count;
      endcase
      pipe_vld_nxt     = pipe_vld;
      pipe_last_nxt    = pipe_last;
      pipe_vld_nxt[0]  = issue;
      pipe_last_nxt[0] = issue & (remaining == RemOne);
      for (int i = 1; i < ReadLatency; i++) begin
         pipe_vld_nxt[i]  = pipe_vld[i-1];
         pipe_last_nxt[i] = pipe_last[i-1];
      end
      credit_nxt = {1'b0, inflight_nxt} + {1'b0, fifo_count_nxt};
      // Issue next cycle only if a FIFO slot is still guaranteed for it.
      ce0_nxt = (state_nxt == RUN) && (remaining_nxt != RemZero) && (credit_nxt < CreditMax);
   end

   // Control state, counters, FIFO bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         addr         <= AddrZero;
         remaining    <= RemZero;
         inflight     <= CntZero;
         fifo_count   <= CntZero;
         pipe_vld     <= {ReadLatency{1'b0}};
         pipe_last    <= {ReadLatency{1'b0}};
         fifo_last    <= {FifoDepth{1'b0}};
         wr_ptr       <= PtrZero;
         rd_ptr       <= PtrZero;
         busy         <= 1'b0;
         done         <= 1'b0;
         mem_ce0      <= 1'b0;
         mem_address0 <= AddrZero;
         m_tvalid     <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr       <= addr_nxt;
         remaining  <= remaining_nxt;
         inflight   <= inflight_nxt;
         fifo_count <= fifo_count_nxt;
         pipe_vld   <= pipe_vld_nxt;
         pipe_last  <= pipe_last_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
         mem_ce0    <= ce0_nxt;
         m_tvalid   <= (fifo_count_nxt != CntZero);
         if (ce0_nxt) begin
            mem_address0 <= addr_nxt;
         end
         if (push) begin
            fifo_last[wr_ptr] <= ret_last;
            wr_ptr            <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
      end
   end

   // FIFO data storage; contents are qualified by m_tvalid, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_q0;
      end
   end

endmodule

// File: tb/tb_local_sp_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_local_sp_stream_reader
//   Directed bench for local_sp_stream_reader. A behavioural memory with a
//   two-cycle read latency supplies known words. Issued reads, stream beats
//   and done pulses are logged on the falling clock edge. Each scenario then
//   compares the logs with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_local_sp_stream_reader;

   localparam int DW = 256;
   localparam int AW = 11;
   localparam int AR = 2048;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          busy, done;
   logic [AW-1:0] mem_address0;
   logic          mem_ce0, mem_we0;
   logic [DW-1:0] mem_d0, mem_q0, m_tdata;
   logic          m_tvalid, m_tready, m_tlast;

   local_sp_stream_reader #(
      .DataWidth(256), .AddressWidth(11), .AddressRange(2048),
      .ReadLatency(2), .FifoDepth(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .count(count), .busy(busy), .done(done), .mem_address0(mem_address0),
      .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   // Memory image: every address holds a distinct word.
   function automatic logic [DW-1:0] word_of(input int i);
      logic [31:0] v;
      v = i;
      return {4{~v, v ^ 32'hC0DE_0000}};
   endfunction

   logic [DW-1:0] mem [AR];
   logic [DW-1:0] rd1;

   // Two-stage read pipe; junk appears on q0 when no read was issued.
   always @(posedge clk) begin
      rd1    <= (mem_ce0 && !mem_we0) ? mem[mem_address0] : {8{32'hDEAD_BEEF}};
      mem_q0 <= rd1;
   end

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int start_cyc = 0;

   logic [AW-1:0] iss_addr[$];
   int            iss_cyc[$];
   logic [DW-1:0] beat_data[$];
   logic          beat_last[$];
   int            beat_cyc[$];
   int            done_cnt  = 0;
   int            done_cyc  = -1;
   int            stab_viol = 0;
   int            we_viol   = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   always @(posedge clk) cyc <= cyc + 1;

   // Event logger; cycle 1 is the cycle right after the accepting edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_ce0) begin
            iss_addr.push_back(mem_address0);
            iss_cyc.push_back(cyc - start_cyc + 1);
         end
         if (m_tvalid && m_tready) begin
            beat_data.push_back(m_tdata);
            beat_last.push_back(m_tlast);
            beat_cyc.push_back(cyc - start_cyc + 1);
         end
         if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - start_cyc + 1;
         end
         if (mem_we0 !== 1'b0 || mem_d0 !== {DW{1'b0}}) we_viol = we_viol + 1;
         if (prev_hold && !(m_tvalid && m_tdata === prev_data && m_tlast === prev_last))
            stab_viol = stab_viol + 1;
         prev_hold = m_tvalid && !m_tready;
         prev_data = m_tdata;
         prev_last = m_tlast;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      iss_addr.delete();
      iss_cyc.delete();
      beat_data.delete();
      beat_last.delete();
      beat_cyc.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      count     = c;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
      clear_log();
   endtask

   // Waits for done within a cycle budget; stress mode randomises m_tready
   // and fires a start pulse mid-command, which must be ignored.
   task automatic wait_done(input string tag, input int budget, input bit stress);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (stress) begin
            m_tready = ($urandom_range(0, 1) == 1);
            if (n == 200) begin
               start     = 1'b1;
               base_addr = 11'd0;
               count     = 12'd5;
            end
         end
         @(negedge clk);
         n = n + 1;
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      m_tready = 1'b1;
      repeat (4) @(negedge clk);
      check_eq({tag, "_done_pulses"}, DW'(done_cnt), DW'(1));
      check_eq({tag, "_busy_after"}, DW'(busy), DW'(0));
   endtask

   task automatic verify_stream(input string tag, input int base, input int n);
      int bad;
      int abad;
      logic [AW-1:0] ea;
      bad  = 0;
      abad = 0;
      check_eq({tag, "_beats"}, DW'(beat_data.size()), DW'(n));
      check_eq({tag, "_issues"}, DW'(iss_addr.size()), DW'(n));
      for (int i = 0; i < beat_data.size(); i++) begin
         if (beat_data[i] !== word_of((base + i) % AR) || beat_last[i] !== (i == n - 1))
            bad = bad + 1;
      end
      for (int i = 0; i < iss_addr.size(); i++) begin
         ea = AW'((base + i) % AR);
         if (iss_addr[i] !== ea) abad = abad + 1;
      end
      check_eq({tag, "_bad_beats"}, DW'(bad), DW'(0));
      check_eq({tag, "_bad_addrs"}, DW'(abad), DW'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, DW'(busy), DW'(0));
      check_eq({tag, "_done"}, DW'(done), DW'(0));
      check_eq({tag, "_ce0"}, DW'(mem_ce0), DW'(0));
      check_eq({tag, "_addr"}, DW'(mem_address0), DW'(0));
      check_eq({tag, "_tvalid"}, DW'(m_tvalid), DW'(0));
      check_eq({tag, "_tlast"}, DW'(m_tlast), DW'(0));
      check_eq({tag, "_tdata"}, m_tdata, {DW{1'b0}});
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < AR; i++) mem[i] = word_of(i);
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = 11'd0;
      count     = 12'd0;
      m_tready  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic four-word read with exact cycle timing
      m_tready = 1'b1;
      do_start(11'd5, 12'd4);
      wait_done("t2", 40, 1'b0);
      check_eq("t2_issues", DW'(iss_addr.size()), DW'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < iss_addr.size()) begin
            check_eq("t2_iss_addr", DW'(iss_addr[i]), DW'(5 + i));
            check_eq("t2_iss_cyc", DW'(iss_cyc[i]), DW'(1 + i));
         end
      end
      check_eq("t2_beats", DW'(beat_data.size()), DW'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < beat_data.size()) begin
            check_eq("t2_beat_data", beat_data[i], word_of(5 + i));
            check_eq("t2_beat_cyc", DW'(beat_cyc[i]), DW'(4 + i));
            check_eq("t2_beat_last", DW'(beat_last[i]), DW'(i == 3));
         end
      end
      check_eq("t2_done_cyc", DW'(done_cyc), DW'(8));

      // Address wrap at the top of memory
      do_start(11'd2046, 12'd4);
      wait_done("t3", 40, 1'b0);
      verify_stream("t3", 2046, 4);

      // Zero-length command
      do_start(11'd9, 12'd0);
      wait_done("t4", 20, 1'b0);
      check_eq("t4_issues", DW'(iss_addr.size()), DW'(0));
      check_eq("t4_beats", DW'(beat_data.size()), DW'(0));
      check_eq("t4_done_cyc", DW'(done_cyc), DW'(1));

      // Backpressure: issue stalls at FIFO depth, then drains in order
      m_tready = 1'b0;
      do_start(11'd0, 12'd16);
      repeat (20) @(negedge clk);
      check_eq("t5_stall_issues", DW'(iss_addr.size()), DW'(4));
      check_eq("t5_stall_beats", DW'(beat_data.size()), DW'(0));
      check_eq("t5_stall_ce0", DW'(mem_ce0), DW'(0));
      check_eq("t5_stall_tvalid", DW'(m_tvalid), DW'(1));
      check_eq("t5_stall_tdata", m_tdata, word_of(0));
      check_eq("t5_stall_busy", DW'(busy), DW'(1));
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      wait_done("t5", 100, 1'b0);
      verify_stream("t5", 0, 16);

      // Reset in the middle of a command with reads in flight
      m_tready = 1'b0;
      do_start(11'd0, 12'd16);
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("t1_rst");
      clear_log();
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      m_tready = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t1_no_done", DW'(done_cnt), DW'(0));
      check_eq("t1_no_beats", DW'(beat_data.size()), DW'(0));
      check_eq("t1_no_issue", DW'(iss_addr.size()), DW'(0));
      do_start(11'd0, 12'd2);
      wait_done("t1", 40, 1'b0);
      verify_stream("t1", 0, 2);

      // Full-memory read with random backpressure and an ignored start
      do_start(11'd100, 12'd2048);
      wait_done("t6", 20000, 1'b1);
      verify_stream("t6", 100, 2048);
      check_eq("t6_stability", DW'(stab_viol), DW'(0));
      check_eq("t6_we_tieoff", DW'(we_viol), DW'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
